rpsc_annunciator_panel: RTL and testbench
=========================================

# rpsc_annunciator_panel

Front-panel annunciator sequencer that consumes the eight first-fault output (`FF_OUT`) and lamp-active (`FF_LA`) lines driven by the RPSC first-fault card. It drives the operator lamps and horn. It also services the acknowledge, reset and lamp-test pushbuttons, using a per-channel alarm sequence with first-out indication.

## Interface
- `N_CH`, 8 — number of fault channels; fixed at 8.
- `FLASH_DIV`, 2_500_000 — clock cycles per fast-flash half-period.
- `DEBOUNCE_CYCLES`, 500_000 — cycles a synchronized pushbutton must be stable before it is accepted.
- `clk` in 1 — system clock.
- `reset` in 1 — asynchronous, active-low reset.
- `i_ff_out` in 8 — first-fault lines from the card; bit k corresponds to FFk+1.
- `i_ff_la` in 8 — lamp/alarm-active lines from the card.
- `i_ack_pb` in 1 — acknowledge pushbutton; raw and active-high.
- `i_reset_pb` in 1 — alarm-reset pushbutton; raw and active-high.
- `i_lamp_test` in 1 — lamp-test pushbutton; raw and active-high.
- `o_lamp` out 8 — lamp drives.
- `o_horn` out 1 — audible alarm.
- `o_first_valid` out 1 — at least one channel is in FIRST.
- `o_first_id` out 3 — lowest channel index currently in FIRST.

## Operation
- Input conditioning:
  - `i_ff_out` and `i_ff_la` pass through 2-flop synchronizers.
  - Each of the three pushbuttons passes through a 2-flop synchronizer, then a debouncer.
  - A debounced rising edge of ack or reset produces a 1-cycle pulse.
  - Lamp test is used as a debounced level.
- Per-channel FSM, with states IDLE, FIRST, ALERT, ACK and RINGBACK (la = synchronized `i_ff_la[k]`, fo = synchronized `i_ff_out[k]`):
  - IDLE: la&fo → FIRST; la&!fo → ALERT.
  - FIRST / ALERT: on an ack pulse, go to ACK if la is high, otherwise go to IDLE. The reset pulse is ignored in these states.
  - ACK: la low → RINGBACK. Ack is ignored.
  - RINGBACK: reset pulse → IDLE. la reasserted → ALERT (never FIRST). Ack is ignored.
- Simultaneous events:
  - An ack pulse in the same cycle that IDLE leaves for FIRST/ALERT does not acknowledge the new alarm.
  - Ack and reset in the same cycle: each channel acts only on the pulse its current state accepts.
- Lamp pattern:
  - IDLE: off.
  - FIRST: fast flash.
  - ALERT: slow flash.
  - ACK: steady on.
  - RINGBACK: fast AND slow, which gives bursts.
- Flash generator:
  - A prescaler toggles the fast phase every `FLASH_DIV` cycles.
  - The slow phase toggles on every 4th fast toggle.
  - Both phases reset to 0 (lamp off phase).
- Lamp test held: all `o_lamp` are 1. FSM states, horn and first-out are unaffected.
- Horn: `o_horn` = OR over channels of (state ∈ {FIRST, ALERT}).
- First-out: `o_first_valid` = any channel in FIRST. `o_first_id` is the lowest such index; it is 0 when none.

## Timing
- Reset (async, immediate):
  - All FSMs go to IDLE.
  - The prescaler and both flash phases clear.
  - Debouncers clear to "released".
  - `o_lamp`=0, `o_horn`=0, `o_first_valid`=0, `o_first_id`=0.
- Reset asserted mid-sequence discards all alarm history. After release, still-active la inputs re-enter FIRST/ALERT as new alarms.
- All outputs are registered.
- Fault input latency:
  - An `i_ff_la`/`i_ff_out` change sampled at edge N updates the FSM state at N+2.
  - The outputs update at N+3.
- Pushbutton latency:
  - The pulse is generated `DEBOUNCE_CYCLES` after the synchronized level stabilizes.
  - The FSM acts on the next edge; outputs follow 1 cycle later.
  - Bounce shorter than `DEBOUNCE_CYCLES` is rejected.
  - A held button produces exactly one pulse.
- Flash period: fast = 2·`FLASH_DIV` cycles; slow = 8·`FLASH_DIV` cycles.
- The prescaler is free-running and wraps, so all flashing channels are phase-aligned.

## Configuration
- Macro: `RPSC_ANN_RINGBACK_EN`.
- Defined: the RINGBACK state and reset-pushbutton handling are as described above.
- Undefined:
  - ACK goes directly to IDLE when la falls.
  - The RINGBACK state does not exist.
  - `i_reset_pb` is ignored and its debouncer is not instantiated.

## Structure
- Package `rpsc_ann_pkg` contains:
  - `ann_state_t` enum (IDLE, FIRST, ALERT, ACK, RINGBACK).
  - `RPSC_N_CH` = 8.
  - `SLOW_RATIO` = 4.
- Sub-module `rpsc_pb_debounce`:
  - Contains the 2-flop synchronizer, the stable counter, the debounced level output and the rising-edge pulse output.
  - Instantiated once per pushbutton.
- Per-channel FSMs are built with a generate loop in the top.

## Test plan
Benches use `FLASH_DIV`=4 and `DEBOUNCE_CYCLES`=3.
- Reset, then idle: all outputs 0; `o_lamp` stays 0 for 100 cycles.
- Raise `i_ff_la[2]` and `i_ff_out[2]`:
  - `o_first_valid`=1, `o_first_id`=2, `o_horn`=1.
  - `o_lamp[2]` toggles every 4 cycles.
  - Then raise `i_ff_la[5]` only: `o_lamp[5]` toggles every 16 cycles; `o_first_id` stays 2.
- Press ack for 10 cycles with la[2] still high:
  - `o_lamp[2]` goes steady 1; `o_horn`=0 when no channel is left in FIRST/ALERT.
  - A 2-cycle glitch on ack produces no effect.
- Drop la[2] with ringback enabled:
  - `o_lamp[2]` shows the burst pattern.
  - A reset press returns the lamp to 0.
  - Re-raising la[2] in RINGBACK gives a slow flash and `o_first_valid`=0.
- Hold lamp test with ch2 in ACK: all 8 lamps are 1. On release, ch2 returns to steady on and ch5's flash is unaffected.
- Assert `reset` low mid-flash: all outputs go to 0 asynchronously.

Source files
------------

// File: rtl/rpsc_ann_pkg.sv
// Shared types and constants for the RPSC annunciator panel.
// The RINGBACK state is always encoded; it is only reachable when RPSC_ANN_RINGBACK_EN is defined.
package rpsc_ann_pkg;

    localparam int unsigned RPSC_N_CH  = 8;
    localparam int unsigned SLOW_RATIO = 4;

    typedef enum logic [2:0] {
        IDLE,
        FIRST,
        ALERT,
        ACK,
        RINGBACK
    } ann_state_t;

    // RINGBACK gates the fast flash with the slow phase, producing bursts.
    function automatic logic lamp_pattern(input ann_state_t st, input logic fast, input logic slow);
        logic on;
        case (st)
            FIRST:    on = fast;
            ALERT:    on = slow;
            ACK:      on = 1'b1;
            RINGBACK: on = fast & slow;
            default:  on = 1'b0;
        endcase
        return on;
    endfunction

endpackage

// File: rtl/rpsc_pb_debounce.sv
// Pushbutton conditioner: 2-flop synchronizer, stability counter, debounced level and rising-edge pulse.
module rpsc_pb_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic clk,
    input  logic reset,
    input  logic pb,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1;
    logic          sync2;
    logic [CW-1:0] cnt;

    // Any return to the accepted level restarts the count, so short bounces never get through.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            cnt   <= '0;
            level <= 1'b0;
            rise  <= 1'b0;
        end else begin
            sync1 <= pb;
            sync2 <= sync1;
            rise  <= 1'b0;
            if (sync2 == level) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt   <= '0;
                level <= sync2;
                rise  <= sync2;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/rpsc_annunciator_panel.sv
// Annunciator sequencer: per-channel alarm FSMs, flash generator, horn and first-out indication.
// Optional ringback sequence and reset pushbutton enabled by `define RPSC_ANN_RINGBACK_EN.
module rpsc_annunciator_panel
    import rpsc_ann_pkg::*;
#(
    parameter int unsigned N_CH            = RPSC_N_CH,
    parameter int unsigned FLASH_DIV       = 2_500_000,
    parameter int unsigned DEBOUNCE_CYCLES = 500_000
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] i_ff_out,
    input  logic [N_CH-1:0] i_ff_la,
    input  logic            i_ack_pb,
    input  logic            i_reset_pb,
    input  logic            i_lamp_test,
    output logic [N_CH-1:0] o_lamp,
    output logic            o_horn,
    output logic            o_first_valid,
    output logic [2:0]      o_first_id
);

    localparam int unsigned PW = (FLASH_DIV > 1) ? $clog2(FLASH_DIV) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(FLASH_DIV - 1);
    localparam int unsigned SW = $clog2(SLOW_RATIO);
    localparam logic [SW-1:0] SLOW_LAST = SW'(SLOW_RATIO - 1);

    logic [N_CH-1:0] la_s1, la_s2;
    logic [N_CH-1:0] fo_s1, fo_s2;
    logic            ack_p;
    logic            lt_level;
    logic            unused_ack_level;
    logic            unused_lt_rise;
    logic [PW-1:0]   pre;
    logic [SW-1:0]   tog;
    logic            fast;
    logic            slow;
    logic [N_CH-1:0] is_first;
    logic [N_CH-1:0] is_alarm;
    logic [N_CH-1:0] lamp_d;
    logic [2:0]      first_id;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            la_s1 <= '0;
            la_s2 <= '0;
            fo_s1 <= '0;
            fo_s2 <= '0;
        end else begin
            la_s1 <= i_ff_la;
            la_s2 <= la_s1;
            fo_s1 <= i_ff_out;
            fo_s2 <= fo_s1;
        end
    end

    rpsc_pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_ack_db (
        .clk   (clk),
        .reset (reset),
        .pb    (i_ack_pb),
        .level (unused_ack_level),
        .rise  (ack_p)
    );

    rpsc_pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lt_db (
        .clk   (clk),
        .reset (reset),
        .pb    (i_lamp_test),
        .level (lt_level),
        .rise  (unused_lt_rise)
    );

`ifdef RPSC_ANN_RINGBACK_EN
    logic rst_p;
    logic unused_rst_level;

    rpsc_pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_rst_db (
        .clk   (clk),
        .reset (reset),
        .pb    (i_reset_pb),
        .level (unused_rst_level),
        .rise  (rst_p)
    );
`else
    logic unused_reset_pb;
    assign unused_reset_pb = i_reset_pb;
`endif

    // Free-running prescaler keeps every flashing channel phase-aligned.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre  <= '0;
            tog  <= '0;
            fast <= 1'b0;
            slow <= 1'b0;
        end else if (pre == PRE_LAST) begin
            pre  <= '0;
            fast <= ~fast;
            if (tog == SLOW_LAST) begin
                tog  <= '0;
                slow <= ~slow;
            end else begin
                tog <= tog + 1'b1;
            end
        end else begin
            pre <= pre + 1'b1;
        end
    end

    for (genvar k = 0; k < N_CH; k++) begin : g_ch
        ann_state_t st;

        // IDLE ignores ack, so a pulse coinciding with a new alarm cannot acknowledge it.
        always_ff @(posedge clk or negedge reset) begin
            if (!reset) begin
                st <= IDLE;
            end else begin
                case (st)
                    IDLE: begin
                        if (la_s2[k]) st <= fo_s2[k] ? FIRST : ALERT;
                    end
                    FIRST, ALERT: begin
                        if (ack_p) st <= la_s2[k] ? ACK : IDLE;
                    end
                    ACK: begin
`ifdef RPSC_ANN_RINGBACK_EN
                        if (!la_s2[k]) st <= RINGBACK;
`else
                        if (!la_s2[k]) st <= IDLE;
`endif
                    end
`ifdef RPSC_ANN_RINGBACK_EN
                    RINGBACK: begin
                        if (rst_p)         st <= IDLE;
                        else if (la_s2[k]) st <= ALERT;
                    end
`endif
                    default: st <= IDLE;
                endcase
            end
        end

        assign is_first[k] = (st == FIRST);
        assign is_alarm[k] = (st == FIRST) || (st == ALERT);
        assign lamp_d[k]   = lamp_pattern(st, fast, slow);
    end

    always_comb begin
        first_id = '0;
        for (int unsigned k = N_CH; k > 0; k--) begin
            if (is_first[k-1]) first_id = 3'(k - 1);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            o_lamp        <= '0;
            o_horn        <= 1'b0;
            o_first_valid <= 1'b0;
            o_first_id    <= '0;
        end else begin
            o_lamp        <= lt_level ? '1 : lamp_d;
            o_horn        <= |is_alarm;
            o_first_valid <= |is_first;
            o_first_id    <= first_id;
        end
    end

endmodule

// File: tb/tb_rpsc_annunciator_panel.sv
// Scoreboard bench for rpsc_annunciator_panel with FLASH_DIV=4, DEBOUNCE_CYCLES=3.
// Expectations are queued per absolute cycle; the monitor compares on each falling edge.
module tb_rpsc_annunciator_panel;

    localparam int FD = 4;
    localparam int DB = 3;
    localparam int P_OFF = 0, P_FAST = 1, P_SLOW = 2, P_ON = 3, P_BURST = 4;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] ff_out = '0;
    logic [7:0] ff_la = '0;
    logic       ack_pb = 1'b0;
    logic       reset_pb = 1'b0;
    logic       lamp_test = 1'b0;
    logic [7:0] lamp;
    logic       horn;
    logic       first_valid;
    logic [2:0] first_id;

    int cyc = 0;
    int checks = 0;
    int errors = 0;
    int pat [8];
    bit lt_model = 1'b0;

    typedef struct packed {
        int         c;
        logic [7:0] lamp;
        logic       horn;
        logic       fv;
        logic [2:0] fid;
    } exp_t;

    exp_t  sb [$];
    string sb_name [$];

    rpsc_annunciator_panel #(
        .N_CH            (8),
        .FLASH_DIV       (FD),
        .DEBOUNCE_CYCLES (DB)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .i_ff_out      (ff_out),
        .i_ff_la       (ff_la),
        .i_ack_pb      (ack_pb),
        .i_reset_pb    (reset_pb),
        .i_lamp_test   (lamp_test),
        .o_lamp        (lamp),
        .o_horn        (horn),
        .o_first_valid (first_valid),
        .o_first_id    (first_id)
    );

    always #5 clk = ~clk;

    // Cycle c = number of rising edges since reset release.
    always @(posedge clk or negedge reset) begin
        if (!reset) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // Lamp value seen at cycle c reflects the flash phases one edge earlier.
    function automatic logic pbit(int p, int c);
        logic f, s;
        f = (((c - 1) / FD) % 2) == 1;
        s = (((c - 1) / (4 * FD)) % 2) == 1;
        case (p)
            P_FAST:  return f;
            P_SLOW:  return s;
            P_ON:    return 1'b1;
            P_BURST: return f & s;
            default: return 1'b0;
        endcase
    endfunction

    task automatic exp_range(int c0, int c1, string nm, logic h, logic fv, logic [2:0] fid);
        exp_t e;
        for (int c = c0; c <= c1; c++) begin
            e.c    = c;
            e.horn = h;
            e.fv   = fv;
            e.fid  = fid;
            for (int b = 0; b < 8; b++) e.lamp[b] = lt_model ? 1'b1 : pbit(pat[b], c);
            sb.push_back(e);
            sb_name.push_back(nm);
        end
    endtask

    task automatic check(string nm, int c, logic [7:0] el, logic eh, logic efv, logic [2:0] efid);
        checks++;
        if (lamp !== el || horn !== eh || first_valid !== efv || first_id !== efid) begin
            errors++;
            $display("FAIL %s cyc=%0d lamp=%h want %h horn=%b want %b first_valid=%b want %b first_id=%0d want %0d",
                     nm, c, lamp, el, horn, eh, first_valid, efv, first_id, efid);
        end
    endtask

    task automatic at(int k);
        while (cyc < k) @(negedge clk);
    endtask

    task automatic drain();
        for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge clk);
    endtask

    initial begin : monitor
        exp_t  e;
        string n;
        forever begin
            @(negedge clk);
            while (sb.size() > 0 && sb[0].c <= cyc) begin
                e = sb.pop_front();
                n = sb_name.pop_front();
                if (e.c < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL %s stale expectation cyc=%0d want cyc %0d", n, cyc, e.c);
                end else begin
                    check(n, cyc, e.lamp, e.horn, e.fv, e.fid);
                end
            end
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog timeout cyc=%0d pending=%0d", cyc, sb.size());
        $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        for (int b = 0; b < 8; b++) pat[b] = P_OFF;
        exp_range(0, 0, "reset_state", 0, 0, 0);
        repeat (3) @(negedge clk);
        reset = 1'b1;
        exp_range(1, 100, "idle", 0, 0, 0);

        at(100); ff_la[2] = 1'b1; ff_out[2] = 1'b1;
        exp_range(103, 103, "ff2_latency", 0, 0, 0);
        pat[2] = P_FAST;
        exp_range(104, 119, "ff2_first", 1, 1, 3'd2);

        at(120); ff_la[5] = 1'b1;
        exp_range(123, 123, "ff5_latency", 1, 1, 3'd2);
        pat[5] = P_SLOW;
        exp_range(124, 159, "ff5_alert", 1, 1, 3'd2);

        at(160); ack_pb = 1'b1;
        exp_range(161, 166, "ack_latency", 1, 1, 3'd2);
        pat[2] = P_ON; pat[5] = P_ON;
        exp_range(167, 169, "ack_steady", 0, 0, 0);
        at(170); ack_pb = 1'b0;
        exp_range(171, 195, "ack_held", 0, 0, 0);

        at(200); ff_la[6] = 1'b1;
        pat[6] = P_SLOW;
        exp_range(204, 209, "ff6_alert", 1, 0, 0);
        at(210); ack_pb = 1'b1;
        at(212); ack_pb = 1'b0;
        exp_range(213, 235, "ack_glitch_rejected", 1, 0, 0);

        at(240); lamp_test = 1'b1;
        exp_range(241, 245, "lt_latency", 1, 0, 0);
        lt_model = 1'b1;
        exp_range(246, 255, "lamp_test", 1, 0, 0);
        at(256); lamp_test = 1'b0;
        exp_range(257, 261, "lt_release_latency", 1, 0, 0);
        lt_model = 1'b0;
        exp_range(262, 285, "lt_release", 1, 0, 0);

        at(290); ff_la[2] = 1'b0;
        exp_range(291, 293, "la2_drop_latency", 1, 0, 0);
`ifdef RPSC_ANN_RINGBACK_EN
        pat[2] = P_BURST;
`else
        pat[2] = P_OFF;
`endif
        exp_range(294, 339, "la2_drop", 1, 0, 0);
        at(340); reset_pb = 1'b1;
        exp_range(341, 346, "rst_pb_latency", 1, 0, 0);
        pat[2] = P_OFF;
        exp_range(347, 349, "rst_pb", 1, 0, 0);
        at(350); reset_pb = 1'b0;
        exp_range(351, 365, "rst_pb_release", 1, 0, 0);

        at(370); ff_la[2] = 1'b1;
        exp_range(371, 373, "ff2_rearm_latency", 1, 0, 0);
        pat[2] = P_FAST;
        exp_range(374, 379, "ff2_rearm", 1, 1, 3'd2);
        at(380); ack_pb = 1'b1;
        exp_range(381, 386, "ack2_latency", 1, 1, 3'd2);
        pat[2] = P_ON; pat[6] = P_ON;
        exp_range(387, 389, "ack2", 0, 0, 0);
        at(390); ack_pb = 1'b0;
        exp_range(391, 399, "ack2_held", 0, 0, 0);

        at(400); ff_la[2] = 1'b0;
        exp_range(401, 403, "ack_la_drop_latency", 0, 0, 0);
`ifdef RPSC_ANN_RINGBACK_EN
        pat[2] = P_BURST;
`else
        pat[2] = P_OFF;
`endif
        exp_range(404, 419, "ack_la_drop", 0, 0, 0);
        at(420); ff_la[2] = 1'b1;
        exp_range(421, 423, "realarm_latency", 0, 0, 0);
`ifdef RPSC_ANN_RINGBACK_EN
        pat[2] = P_SLOW;
        exp_range(424, 440, "ringback_realarm", 1, 0, 0);
`else
        pat[2] = P_FAST;
        exp_range(424, 440, "idle_realarm", 1, 1, 3'd2);
`endif
        drain();

        @(posedge clk); #2;
        reset = 1'b0;
        #1;
        check("async_reset", cyc, 8'h00, 1'b0, 1'b0, 3'd0);
        for (int b = 0; b < 8; b++) pat[b] = P_OFF;
        exp_range(1, 3, "post_reset_latency", 0, 0, 0);
        pat[2] = P_FAST; pat[5] = P_SLOW; pat[6] = P_SLOW;
        exp_range(4, 40, "post_reset_realarm", 1, 1, 3'd2);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        drain();

        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL pending_expectations left=%0d want 0", sb.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
